// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scan driver.
// Holds the scan FSM state encoding and the pin polarity mapping.
package led_matrix_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Map a logical "active" value onto the physical pin level.
    function automatic logic pin_level(input logic active, input bit act_low);
        return active ^ act_low;
    endfunction

endpackage

// File: rtl/led_row_pwm.sv
// Per-row phase counter: times the BLANK guard and the DRIVE dwell,
// and gates the cathodes with the brightness-dependent on-window.
module led_row_pwm
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 12800,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 3
) (
    input  logic                clk_master,
    input  logic                reset_master,
    input  scan_state_t         state,
    input  logic [BRIGHT_W-1:0] bright_q,
    output logic                blank_done,
    output logic                dwell_done,
    output logic                phase_start,
    output logic                pwm_on
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int SLICE   = DWELL_CYCLES >> BRIGHT_W;

    logic [CNT_W-1:0] cnt;
    logic [31:0]      on_lim;

    assign blank_done  = (32'(cnt) == BLANK_CYCLES - 1);
    assign dwell_done  = (32'(cnt) == DWELL_CYCLES - 1);
    assign phase_start = (cnt == '0);
    assign on_lim      = (32'(bright_q) + 32'd1) * 32'(SLICE);
    assign pwm_on      = (32'(cnt) < on_lim);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_master or posedge reset_master) begin
        if (reset_master) begin
            cnt <= '0;
        end else if ((state == BLANK) ? blank_done : dwell_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_matrix_scan_driver.sv
// Row-scan driver for a ROWS x COLS LED matrix with double-buffered frames,
// inter-row blanking, per-row PWM brightness and configurable pin polarity.
module led_matrix_scan_driver
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES  = 12800,
    parameter int BLANK_CYCLES  = 16,
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int BRIGHT_W      = 3,
    parameter bit ANODE_ACT_LOW = 1'b1,
    parameter bit CATH_ACT_LOW  = 1'b1
) (
    input  logic                    clk_master,
    input  logic                    reset_master,
    input  logic [ROWS*COLS-1:0]    frame_in,
    input  logic                    frame_load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [ROWS-1:0]         out_anode,
    output logic [COLS-1:0]         out_cathode,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    frame_start
);

    localparam int RW = $clog2(ROWS);

    scan_state_t          state;
    logic [RW-1:0]        row;
    logic [BRIGHT_W-1:0]  bright_q;
    logic [ROWS*COLS-1:0] shadow;
    logic [ROWS*COLS-1:0] disp_buf;
    logic                 pending;
    logic                 blank_done, dwell_done, phase_start, pwm_on;
    logic                 frame_edge;
    logic [ROWS-1:0]      anode_pin;
    logic [COLS-1:0]      cath_pin;

    led_row_pwm #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BRIGHT_W     (BRIGHT_W)
    ) u_row_pwm (
        .clk_master   (clk_master),
        .reset_master (reset_master),
        .state        (state),
        .bright_q     (bright_q),
        .blank_done   (blank_done),
        .dwell_done   (dwell_done),
        .phase_start  (phase_start),
        .pwm_on       (pwm_on)
    );

    // First cycle of row 0's blanking guard: the only point disp_buf may change.
    assign frame_edge = (state == BLANK) && (row == '0) && phase_start;

    always_ff @(posedge clk_master or posedge reset_master) begin
        if (reset_master) begin
            state    <= BLANK;
            row      <= '0;
            bright_q <= '0;
        end else begin
            case (state)
                BLANK: if (blank_done) begin
                    state    <= DRIVE;
                    bright_q <= brightness;
                end
                DRIVE: if (dwell_done) begin
                    state <= BLANK;
                    row   <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
                end
                default: state <= BLANK;
            endcase
        end
    end

    always_ff @(posedge clk_master or posedge reset_master) begin
        if (reset_master) begin
            shadow   <= '0;
            disp_buf <= '0;
            pending  <= 1'b0;
        end else begin
            if (frame_edge && pending) begin
                disp_buf <= shadow;
            end
            // A load on the swap cycle lands in shadow and stays pending.
            if (frame_load) begin
                shadow  <= frame_in;
                pending <= 1'b1;
            end else if (frame_edge) begin
                pending <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        anode_pin = '0;
        cath_pin  = '0;
        for (int r = 0; r < ROWS; r++) begin
            anode_pin[r] = pin_level((state == DRIVE) && (row == RW'(r)), ANODE_ACT_LOW);
        end
        for (int c = 0; c < COLS; c++) begin
            cath_pin[c] = pin_level((state == DRIVE) && pwm_on && disp_buf[row*COLS + c],
                                    CATH_ACT_LOW);
        end
    end

    always_ff @(posedge clk_master or posedge reset_master) begin
        if (reset_master) begin
            out_anode   <= {ROWS{ANODE_ACT_LOW}};
            out_cathode <= {COLS{CATH_ACT_LOW}};
            row_idx     <= '0;
            frame_start <= 1'b0;
        end else begin
            out_anode   <= anode_pin;
            out_cathode <= cath_pin;
            row_idx     <= row;
            frame_start <= frame_edge;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Self-checking bench for led_matrix_scan_driver (4x4, dwell 8, blank 2).
// Expected pins are derived from the cycle position within the frame period.
module tb_led_matrix_scan_driver;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DWELL  = 8;
    localparam int BLANK  = 2;
    localparam int BW     = 2;
    localparam int ROWP   = BLANK + DWELL;
    localparam int PERIOD = ROWS * ROWP;

    logic        clk_master   = 1'b0;
    logic        reset_master = 1'b1;
    logic [15:0] frame_in     = '0;
    logic        frame_load   = 1'b0;
    logic [1:0]  brightness   = '0;
    logic [3:0]  out_anode;
    logic [3:0]  out_cathode;
    logic [1:0]  row_idx;
    logic        frame_start;

    led_matrix_scan_driver #(
        .DWELL_CYCLES  (DWELL),
        .BLANK_CYCLES  (BLANK),
        .ROWS          (ROWS),
        .COLS          (COLS),
        .BRIGHT_W      (BW),
        .ANODE_ACT_LOW (1'b1),
        .CATH_ACT_LOW  (1'b1)
    ) dut (
        .clk_master   (clk_master),
        .reset_master (reset_master),
        .frame_in     (frame_in),
        .frame_load   (frame_load),
        .brightness   (brightness),
        .out_anode    (out_anode),
        .out_cathode  (out_cathode),
        .row_idx      (row_idx),
        .frame_start  (frame_start)
    );

    always #5 clk_master = ~clk_master;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: edges since reset release, buffers, latched brightness.
    int          n;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    bit          m_pending;
    int          m_bright;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s (edge %0d): observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        m_shadow  = '0;
        m_disp    = '0;
        m_pending = 1'b0;
        m_bright  = 0;
    endtask

    task automatic model_edge(input bit ld, input logic [15:0] d, input logic [1:0] b);
        int p;
        n++;
        p = (n - 1) % PERIOD;
        if (p % ROWP == BLANK - 1) m_bright = int'(b);
        if (p == 0 && m_pending) begin
            m_disp    = m_shadow;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_shadow  = d;
            m_pending = 1'b1;
        end
    endtask

    task automatic check_outputs();
        int         p, r, q, k;
        logic [3:0] ea, ec, lit;
        logic       efs;
        if (reset_master || n == 0) begin
            ea = 4'hF; ec = 4'hF; r = 0; efs = 1'b0;
        end else begin
            p   = (n - 1) % PERIOD;
            r   = p / ROWP;
            q   = p % ROWP;
            efs = (p == 0);
            if (q < BLANK) begin
                ea = 4'hF;
                ec = 4'hF;
            end else begin
                k   = q - BLANK;
                ea  = ~(4'b0001 << r);
                lit = (k < (m_bright + 1) * (DWELL >> BW)) ? m_disp[r*COLS +: COLS] : 4'h0;
                ec  = ~lit;
            end
        end
        check("anode",       16'(out_anode),   16'(ea));
        check("cathode",     16'(out_cathode), 16'(ec));
        check("row_idx",     16'(row_idx),     16'(r));
        check("frame_start", 16'(frame_start), 16'(efs));
    endtask

    task automatic step(input bit ld, input logic [15:0] d, input logic [1:0] b);
        frame_load = ld;
        frame_in   = d;
        brightness = b;
        @(posedge clk_master);
        if (reset_master) model_reset();
        else              model_edge(ld, d, b);
        #1 check_outputs();
    endtask

    initial begin
        model_reset();

        // Reset held, then one full frame plus the next frame boundary.
        repeat (3) step(1'b0, 16'h0, 2'd0);
        reset_master = 1'b0;
        repeat (PERIOD + 2) step(1'b0, 16'h0, 2'd0);

        // Diagonal scan order at full brightness.
        step(1'b1, 16'h8421, 2'd3);
        repeat (2 * PERIOD) step(1'b0, 16'h0, 2'd3);

        // PWM: dimmest, then level 1, then brightness jittering mid-row.
        step(1'b1, 16'hFFFF, 2'd0);
        repeat (2 * PERIOD) step(1'b0, 16'h0, 2'd0);
        repeat (PERIOD) step(1'b0, 16'h0, 2'd1);
        repeat (PERIOD) step(1'b0, 16'h0, 2'($urandom_range(0, 3)));

        // Tear-free: blank frame shown, all-lit frame loaded mid-frame.
        step(1'b1, 16'h0000, 2'd3);
        repeat (PERIOD) step(1'b0, 16'h0, 2'd3);
        while (n % PERIOD != 15) step(1'b0, 16'h0, 2'd3);
        step(1'b1, 16'hFFFF, 2'd3);
        repeat (2 * PERIOD) step(1'b0, 16'h0, 2'd3);

        // Two loads in one frame: only the last is displayed.
        while (n % PERIOD != 5) step(1'b0, 16'h0, 2'd3);
        step(1'b1, 16'h000F, 2'd3);
        repeat (7) step(1'b0, 16'h0, 2'd3);
        step(1'b1, 16'hF000, 2'd3);
        repeat (2 * PERIOD) step(1'b0, 16'h0, 2'd3);

        // Load on the swap cycle: old shadow shown first, new data a frame later.
        while (n % PERIOD != 20) step(1'b0, 16'h0, 2'd3);
        step(1'b1, 16'hA5A5, 2'd3);
        while (n % PERIOD != 0) step(1'b0, 16'h0, 2'd3);
        step(1'b1, 16'h1234, 2'd3);
        repeat (2 * PERIOD) step(1'b0, 16'h0, 2'd3);

        // Async reset in the middle of row 2's DRIVE phase.
        while (n % PERIOD != 25) step(1'b0, 16'h0, 2'd3);
        #3 reset_master = 1'b1;
        #1 check_outputs();
        model_reset();
        repeat (2) step(1'b0, 16'h0, 2'd3);
        reset_master = 1'b0;
        repeat (PERIOD + 1) step(1'b0, 16'h0, 2'd3);

        // Randomised loads, data and brightness.
        repeat (400) step(($urandom_range(0, 29) == 0), 16'($urandom), 2'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
